// File: rtl/denise_bitplane_shifter_pkg.sv
// Shared definitions for the Denise bitplane shifter slice.
// Build option: BPL_AGA_PLANES_EN -- when defined, eight bitplanes are
// implemented regardless of the NPLANES parameter.
package denise_bitplane_shifter_pkg;

    // Register bus addresses (byte address, bit 0 always zero on the bus).
    localparam logic [8:0] BPL1DAT_ADR = 9'h110;
    localparam logic [8:0] BPLCON0_ADR = 9'h100;
    localparam logic [8:0] BPLCON1_ADR = 9'h102;

    localparam int MAX_PLANES = 8;

`ifdef BPL_AGA_PLANES_EN
    localparam bit AGA_PLANES = 1'b1;
`else
    localparam bit AGA_PLANES = 1'b0;
`endif

    typedef enum logic [1:0] {
        RES_LORES,
        RES_HIRES,
        RES_SHRES
    } res_e;

    // Number of planes actually built: AGA builds always carry all eight.
    function automatic int plane_count(input int requested);
        return AGA_PLANES ? MAX_PLANES : requested;
    endfunction

    // Super-hires takes precedence when both resolution bits are set.
    function automatic res_e resolve_res(input logic hires, input logic shres);
        if (shres) return RES_SHRES;
        if (hires) return RES_HIRES;
        return RES_LORES;
    endfunction

endpackage

// File: rtl/denise_bitplane_shifter_if.sv
// Register-bus and pixel-output bundle of the bitplane shifter.
// Build option: BPL_AGA_PLANES_EN widens bpldata to eight planes.
interface denise_bitplane_shifter_if #(
    parameter int NPLANES = 6
);
    import denise_bitplane_shifter_pkg::*;

    localparam int NP = plane_count(NPLANES);

    logic          clk7_en;
    logic          ecs;
    logic [8:1]    reg_address_in;
    logic [15:0]   data_in;
    logic [NP-1:0] bpldata;
    logic          pix_en;

    modport master (
        output clk7_en, ecs, reg_address_in, data_in,
        input  bpldata, pix_en
    );

    modport slave (
        input  clk7_en, ecs, reg_address_in, data_in,
        output bpldata, pix_en
    );

endinterface

// File: rtl/denise_bpl_shiftreg.sv
// One bitplane serialiser: 16-bit parallel load, MSB-first left shift.
module denise_bpl_shiftreg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        shift,
    input  logic [15:0] din,
    output logic        msb
);

    logic [15:0] sr;

    // Load has priority so a coinciding shift tick never eats the first pixel.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset)
            sr <= '0;
        else if (load)
            sr <= din;
        else if (shift)
            sr <= {sr[14:0], 1'b0};
    end

    assign msb = sr[15];

endmodule

// File: rtl/denise_bitplane_shifter.sv
// Denise bitplane shifter: captures BPLxDAT words, applies the BPLCON1
// playfield scroll delay and serialises the planes at lores/hires/shres.
// Build option: BPL_AGA_PLANES_EN -- eight planes, BPL7DAT/BPL8DAT decoded.
module denise_bitplane_shifter
    import denise_bitplane_shifter_pkg::*;
#(
    parameter int NPLANES = 6
) (
    input  logic clk,
    input  logic reset,
    denise_bitplane_shifter_if.slave bus
);

    localparam int NP = plane_count(NPLANES);

    logic [8:0]    addr;
    logic          wr_bpl1;
    logic          wr_con0;
    logic          wr_con1;
    logic [NP-1:0] wr_hold;

    logic          hires;
    logic          shres;
    logic [3:0]    pf1h;
    logic [3:0]    pf2h;
    logic [15:0]   hold [NP];
    logic [1:0]    ph;

    logic          arm_o;
    logic          arm_e;
    logic [3:0]    dly_o;
    logic [3:0]    dly_e;
    logic          load_o;
    logic          load_e;

    res_e          res;
    logic          shift_tick;
    logic          pix_en_q;
    logic [NP-1:0] pix;

    assign addr = {bus.reg_address_in, 1'b0};

    // Register decode; every bus write is qualified by the lores strobe.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_hold = '0;
        wr_bpl1 = bus.clk7_en && (addr == BPL1DAT_ADR);
        wr_con0 = bus.clk7_en && (addr == BPLCON0_ADR);
        wr_con1 = bus.clk7_en && (addr == BPLCON1_ADR);
        for (int i = 0; i < NP; i++)
            wr_hold[i] = bus.clk7_en && (addr == BPL1DAT_ADR + 9'(2 * i));
    end

    // Resolution and scroll controls from BPLCON0/BPLCON1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hires <= 1'b0;
            shres <= 1'b0;
            pf1h  <= 4'd0;
            pf2h  <= 4'd0;
        end else begin
            if (wr_con0) begin
                hires <= bus.data_in[15];
                shres <= bus.data_in[6] & bus.ecs;
            end
            if (wr_con1) begin
                pf1h <= bus.data_in[3:0];
                pf2h <= bus.data_in[7:4];
            end
        end
    end

    // Per-plane holding registers written by BPLxDAT.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: this small register file must read zero after reset, so it is
        // reset like ordinary flops; a real RAM macro would not be.
        if (reset) begin
            for (int i = 0; i < NP; i++)
                hold[i] <= '0;
        end else begin
            for (int i = 0; i < NP; i++)
                if (wr_hold[i])
                    hold[i] <= bus.data_in;
        end
    end

    // Sub-pixel phase, realigned to zero right after every lores strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ph <= 2'd0;
        else if (bus.clk7_en)
            ph <= 2'd0;
        else
            ph <= ph + 2'd1;
    end

    assign res = resolve_res(hires, shres);

    // Shift rate: every clk (shres), every other clk (hires), per strobe (lores).
    always_comb begin
        shift_tick = 1'b0;
        case (res)
            RES_SHRES: shift_tick = 1'b1;
            RES_HIRES: shift_tick = ph[0] | bus.clk7_en;
            default:   shift_tick = bus.clk7_en;
        endcase
    end

    // A fresh BPL1DAT write cancels any load that would otherwise fire now.
    assign load_o = bus.clk7_en && arm_o && !wr_bpl1 && (dly_o == pf1h);
    assign load_e = bus.clk7_en && arm_e && !wr_bpl1 && (dly_e == pf2h);

    // Scroll delay per playfield: compare first, then count the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_o <= 1'b0;
            arm_e <= 1'b0;
            dly_o <= 4'd0;
            dly_e <= 4'd0;
        end else if (wr_bpl1) begin
            arm_o <= 1'b1;
            arm_e <= 1'b1;
            dly_o <= 4'd0;
            dly_e <= 4'd0;
        end else if (bus.clk7_en) begin
            if (arm_o) begin
                if (load_o)
                    arm_o <= 1'b0;
                else
                    dly_o <= dly_o + 4'd1;
            end
            if (arm_e) begin
                if (load_e)
                    arm_e <= 1'b0;
                else
                    dly_e <= dly_e + 4'd1;
            end
        end
    end

    // pix_en is delayed one clk so it lines up with the shifter outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pix_en_q <= 1'b0;
        else
            pix_en_q <= shift_tick;
    end

    // Odd planes (1,3,5,7 = even indices) follow playfield 1, the rest playfield 2.
    for (genvar i = 0; i < NP; i++) begin : g_plane
        localparam bit ODD_PLANE = (i % 2) == 0;

        denise_bpl_shiftreg u_sr (
            .clk   (clk),
            .reset (reset),
            .load  (ODD_PLANE ? load_o : load_e),
            .shift (shift_tick),
            .din   (hold[i]),
            .msb   (pix[i])
        );
    end

    assign bus.bpldata = pix;
    assign bus.pix_en  = pix_en_q;

endmodule

// File: tb/tb_denise_bitplane_shifter.sv
// Scoreboard bench for denise_bitplane_shifter: stimulus queues the expected
// bpldata for each upcoming pix_en pulse, a monitor pops and compares.
module tb_denise_bitplane_shifter;
    import denise_bitplane_shifter_pkg::*;

    localparam int NP = plane_count(6);

    localparam logic [8:0]    BPL2DAT_ADR = 9'h112;
    localparam logic [8:0]    BPL7DAT_ADR = 9'h11C;
    localparam logic [7:0]    IDLE_ADR    = 8'hFF;
    localparam logic [NP-1:0] P0          = NP'(1);
    localparam logic [NP-1:0] P1          = NP'(2);
    localparam logic [NP-1:0] P01         = NP'(3);
    localparam logic [NP-1:0] ALL         = '1;

    typedef struct {
        logic [NP-1:0] mask;
        logic [NP-1:0] val;
        int            gap;
        string         name;
        int            idx;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint last_pix = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] div;

    denise_bitplane_shifter_if #(.NPLANES(6)) bus ();

    denise_bitplane_shifter #(.NPLANES(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // One-in-four lores strobe, driven just after each rising edge.
    initial begin
        div = 2'd0;
        bus.clk7_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = div + 2'd1;
            bus.clk7_en = (div == 2'd0);
        end
    end

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [NP-1:0] m, input logic [NP-1:0] v,
                        input int gap, input string name, input int idx);
        exp_t e;
        e.mask = m;
        e.val  = v;
        e.gap  = gap;
        e.name = name;
        e.idx  = idx;
        sb.push_back(e);
    endtask

    // Write during the next clk7_en cycle; returns two time units after that edge.
    task automatic bus_write(input logic [8:0] a, input logic [15:0] d);
        do begin
            @(posedge clk);
            #2;
        end while (!bus.clk7_en);
        bus.reg_address_in = a[8:1];
        bus.data_in        = d;
        @(posedge clk);
        #2;
        bus.reg_address_in = IDLE_ADR;
    endtask

    task automatic wait_strobes(input int n);
        for (int k = 0; k < n; k++) begin
            do begin
                @(posedge clk);
                #2;
            end while (!bus.clk7_en);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(sb.size() == 0, {name, " drain timeout, pending entries"}, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: each pix_en pulse consumes one expectation, if any is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.pix_en === 1'b1) begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check((bus.bpldata & e.mask) === e.val,
                          $sformatf("%s[%0d] bpldata", e.name, e.idx),
                          longint'(bus.bpldata & e.mask), longint'(e.val));
                    if (e.gap != 0)
                        check((cyc - last_pix) == longint'(e.gap),
                              $sformatf("%s[%0d] pix_en spacing", e.name, e.idx),
                              cyc - last_pix, longint'(e.gap));
                end
                last_pix = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP-1:0] v;
        bus.ecs            = 1'b0;
        bus.reg_address_in = IDLE_ADR;
        bus.data_in        = 16'h0000;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check(bus.bpldata == '0, "reset bpldata", longint'(bus.bpldata), 0);
        check(bus.pix_en == 1'b0, "reset pix_en", longint'(bus.pix_en), 0);
        reset = 1'b0;

        // Lores, scroll 0, 8001: pixel 1 and 16 set, one pix_en per 4 clk.
        bus_write(BPL1DAT_ADR, 16'h8001);
        push(P0, '0, 0, "lores", 0);
        for (int j = 1; j <= 17; j++)
            push(P0, (j == 1 || j == 16) ? P0 : '0, 4, "lores", j);
        drain("lores");

        // Hires: plane 2 all ones lasts 16 pixels of 2 clk each.
        bus_write(BPLCON0_ADR, 16'h8000);
        bus_write(BPL2DAT_ADR, 16'hFFFF);
        bus_write(BPL1DAT_ADR, 16'h0000);
        push(P1, '0, 0, "hires", 0);
        push(P1, '0, 2, "hires", 1);
        for (int j = 2; j <= 17; j++)
            push(P1, P1, 2, "hires", j);
        push(P1, '0, 2, "hires", 18);
        drain("hires");

        // Shres with ecs: AAAA toggles every clk.
        bus.ecs = 1'b1;
        bus_write(BPLCON0_ADR, 16'h0040);
        bus_write(BPL2DAT_ADR, 16'h0000);
        bus_write(BPL1DAT_ADR, 16'hAAAA);
        push(P0, '0, 0, "shres", 0);
        for (int j = 1; j <= 3; j++)
            push(P0, '0, 1, "shres", j);
        for (int j = 4; j <= 19; j++)
            push(P0, (j % 2 == 0) ? P0 : '0, 1, "shres", j);
        push(P0, '0, 1, "shres", 20);
        drain("shres");

        // Shres bit without ecs stays at lores rate.
        bus.ecs = 1'b0;
        bus_write(BPLCON0_ADR, 16'h0040);
        bus_write(BPL1DAT_ADR, 16'hC000);
        push(P0, '0, 0, "noecs", 0);
        push(P0, P0, 4, "noecs", 1);
        push(P0, P0, 4, "noecs", 2);
        push(P0, '0, 4, "noecs", 3);
        drain("noecs");

        // pf1h=3, pf2h=0: even plane after 1 strobe, odd plane 3 strobes later.
        bus_write(BPLCON1_ADR, 16'h0003);
        bus_write(BPL2DAT_ADR, 16'hFFFF);
        bus_write(BPL1DAT_ADR, 16'hFFFF);
        for (int j = 0; j <= 20; j++) begin
            v = '0;
            v[1] = (j >= 1 && j <= 16);
            v[0] = (j >= 4 && j <= 19);
            push(P01, v, (j == 0) ? 0 : 4, "scroll", j);
        end
        drain("scroll");

        // Re-write at dly_o=2 with pf1h=5: load 6 strobes after the second write.
        bus_write(BPLCON1_ADR, 16'h0005);
        bus_write(BPL1DAT_ADR, 16'hFFFF);
        wait_strobes(2);
        bus_write(BPL1DAT_ADR, 16'hC000);
        push(P0, '0, 0, "rearm", 0);
        for (int j = 1; j <= 5; j++)
            push(P0, '0, 4, "rearm", j);
        push(P0, P0, 4, "rearm", 6);
        push(P0, P0, 4, "rearm", 7);
        push(P0, '0, 4, "rearm", 8);
        drain("rearm");

        // Reset mid-shift with a load pending.
        bus_write(BPLCON1_ADR, 16'h0000);
        bus_write(BPL1DAT_ADR, 16'hFFFF);
        push(P0, '0, 0, "preload", 0);
        for (int j = 1; j <= 3; j++)
            push(P0, P0, 4, "preload", j);
        drain("preload");
        bus_write(BPL1DAT_ADR, 16'hFFFF);
        check(bus.bpldata[0] == 1'b1, "mid-shift bpldata[0]", longint'(bus.bpldata[0]), 1);
        #1;
        reset = 1'b1;
        #1;
        check(bus.bpldata == '0, "async reset bpldata", longint'(bus.bpldata), 0);
        check(bus.pix_en == 1'b0, "async reset pix_en", longint'(bus.pix_en), 0);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        push(ALL, '0, 0, "postreset", 0);
        for (int j = 1; j <= 7; j++)
            push(ALL, '0, 4, "postreset", j);
        drain("postreset");

        // BPL7DAT: decoded only in the eight-plane build.
        bus_write(BPL7DAT_ADR, 16'hFFFF);
        bus_write(BPL1DAT_ADR, 16'h0000);
        v = '0;
`ifdef BPL_AGA_PLANES_EN
        v[6] = 1'b1;
`endif
        push(ALL, '0, 0, "bpl7", 0);
        push(ALL, v, 4, "bpl7", 1);
        push(ALL, v, 4, "bpl7", 2);
        drain("bpl7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/denise_bitplane_shifter.md
# denise_bitplane_shifter

Display-side consumer of the bitplane DMA engine. It captures the BPLxDAT words that the DMA engine addresses on the register bus into per-plane holding registers. A write to BPL1DAT arms a parallel load, delayed per playfield by the BPLCON1 scroll values. The block then serialises the planes at lores, hires or shres rate into a per-pixel colour-index bit vector for the priority/colour stage.

## Interface
Parameters:
- NPLANES, 6: number of bitplanes implemented; forced to 8 when BPL_AGA_PLANES_EN is defined.

Ports:
- clk  in  1  bus clock, 28 MHz (4 ticks per CCK half / lores pixel).
- reset  in  1  asynchronous, active-high; clears all state.
- clk7_en  in  1  one-in-four strobe, lores pixel boundary.
- ecs  in  1  enables the SHRES bit of BPLCON0.
- reg_address_in  in  8 ([8:1])  register bus address.
- data_in  in  16  register bus data.
- bpldata  out  NPLANES  current pixel bit of each plane (bit n = plane n+1).
- pix_en  out  1  high on clocks where bpldata advances.

## Operation
- Register decode is qualified by clk7_en:
  - BPLxDAT at 9'h110 + 2·(x−1), x = 1..NPLANES: write holding register hold[x−1].
  - BPLCON0 9'h100: capture hires = data_in[15] and shres = data_in[6] & ecs.
  - BPLCON1 9'h102: capture pf1h = data_in[3:0] (odd planes) and pf2h = data_in[7:4] (even planes).
- Phase counter ph[1:0]: forced to 0 on the clock after clk7_en, otherwise incremented.
- Shift tick (drives pix_en):
  - shres: every clk.
  - hires: clocks with ph[0] = 1 and clk7_en.
  - lores: clk7_en only.
  - If shres and hires are both set, shres wins.
- Load arm: a BPL1DAT write sets arm_o and arm_e, and clears both delay counters dly_o and dly_e (4 bits each).
- While armed, each delay counter increments on clk7_en.
- Odd load (planes 1,3,5,7): when dly_o == pf1h on a clk7_en clock with arm_o set, copy hold[] into the odd shifters and clear arm_o. Even load (planes 2,4,6,8) works the same way with dly_e and pf2h.
- The load comparison happens before the increment. Scroll 0 therefore loads on the first clk7_en after the write, including the same-cycle write's successor.
- Shifters: 16-bit, MSB first, left shift with zero fill on each shift tick. bpldata[n] = shifter[n][15].
- If a load and a shift tick coincide, the load wins and the shifter holds the new word unshifted.
- A BPL1DAT write while already armed restarts the delay from 0; the pending load is not taken.
- A BPLCON1 write while armed takes effect on the next comparison. If the new scroll value is below the current count, the load waits for the 4-bit counter to wrap.
- Writes to planes beyond NPLANES are ignored.

## Timing
- Reset values:
  - bpldata = 0, pix_en = 0.
  - All hold registers, shifters, counters, arms and control bits = 0.
  - ph = 0.
- The register write lands one clk after the clk7_en bus cycle.
- Load latency from a BPL1DAT write: (scroll + 1) clk7_en strobes.
- The first pixel appears on bpldata the clk after the load. The next bit follows the next shift tick.
- pix_en is registered and aligns with the bpldata change.
- Reset asserted mid-line immediately zeroes bpldata, and no load fires after release.

## Configuration
- BPL_AGA_PLANES_EN:
  - Defined: NPLANES = 8; BPL7DAT and BPL8DAT (9'h11C, 9'h11E) are decoded.
  - Undefined: 6 planes; bpldata is 6 bits wide and 9'h11C/9'h11E are ignored.

## Structure
- The shared package holds:
  - register address constants BPL1DAT_ADR, BPLCON0_ADR, BPLCON1_ADR;
  - MAX_PLANES = 8;
  - a resolution enum {RES_LORES, RES_HIRES, RES_SHRES}.
- One sub-module, denise_bpl_shiftreg: 16-bit load/shift register, instantiated once per plane.

## Test plan
- Lores, scroll 0, BPL1DAT = 16'h8001: bpldata[0] is 1 on the first pixel, 0 for pixels 2–15, 1 on pixel 16; pix_en pulses once per 4 clk.
- Hires, BPL2DAT = 16'hFFFF then BPL1DAT write: bpldata[1] is high for exactly 32 clk.
- Shres (ecs = 1), BPL1DAT = 16'hAAAA: bpldata[0] toggles every clk for 16 clk.
- Shres bit with ecs = 0: lores rate is kept.
- pf1h = 3, pf2h = 0, BPL1DAT and BPL2DAT = 16'hFFFF:
  - even plane loads 1 clk7_en after the write;
  - odd plane loads 3 clk7_en strobes later than the even plane.
- Second BPL1DAT write at dly_o = 2 with pf1h = 5: load fires 6 strobes after the second write, not the first.
- Assert reset mid-shift: bpldata = 0 immediately; no further pix_en with data after release.
- Macro undefined, write 9'h11C: no effect. Macro defined, write 9'h11C = 16'hFFFF: bpldata[6] = 1.
